// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// Instruction queue between fetch (IF) and decode (ID). It is a DEPTH-entry
// circular FIFO followed by the output register that drives ID. Fetch can
// keep running while ID is stalled. The hold / bubble / flush behaviour of the
// earlier single-entry IF/ID register is kept. When the queue is empty and ID
// is not stalled, an accepted instruction bypasses the FIFO and reaches ID one
// cycle after acceptance.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-low reset
//   in_valid      IF presents pc_i / inst_i
//   pc_i, inst_i  fetched PC and instruction word
//   in_ready      queue can accept (combinational from rst and count_o)
//   jump_flag     redirect: flush queue and output register
//   stall_signal  bit2 = hold ID, bit1 = bubble into ID, other bits unused
//   pc_o, inst_o  PC / instruction to ID
//   valid_o       pc_o / inst_o carry a real instruction
//   count_o       queue occupancy, not counting the output register
// ---------------------------------------------------------------------------
module if_id_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [INST_W-1:0] inst_i,
   output logic              in_ready,
   input  logic              jump_flag,
   input  logic [4:0]        stall_signal,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              valid_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
   logic [INST_W-1:0] inst_mem_r [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;

   logic accept_s;
   logic hold_s;
   logic bubble_s;
   logic empty_s;
   logic push_s;
   logic pop_s;
   logic bypass_s;
   logic unused_stall_s;

   // Full blocks acceptance even in a popping cycle, so no same-cycle refill.
   assign in_ready = rst && (count_o != FULL_CNT);
   assign accept_s = in_valid && in_ready;

   // The remaining stall bits belong to other pipeline stages.
   assign unused_stall_s = ^{stall_signal[4:3], stall_signal[0]};

   // Decode this cycle's action: push into FIFO, pop to ID, or bypass.
   always_comb begin
      hold_s   = stall_signal[2];
      bubble_s = stall_signal[1] && !stall_signal[2];
      empty_s  = (count_o == {CNT_W{1'b0}});
      // An accept only lands in the FIFO if it cannot go straight to ID.
      push_s   = accept_s && !jump_flag && (hold_s || bubble_s || !empty_s);
      pop_s    = rst && !jump_flag && !hold_s && !bubble_s && !empty_s;
      bypass_s = accept_s && !jump_flag && !hold_s && !bubble_s && empty_s;
   end

   // FIFO storage write; contents are don't-care until the count covers them.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[wr_ptr_r]   <= pc_i;
         inst_mem_r[wr_ptr_r] <= inst_i;
      end
   end

   // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst || jump_flag) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_o  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (push_s && !pop_s) begin
            count_o <= count_o + CNT_ONE;
         end else if (pop_s && !push_s) begin
            count_o <= count_o - CNT_ONE;
         end else begin
            count_o <= count_o;
         end
      end
   end

   // Output register to ID: clear, hold, load from head, bypass, or bubble.
   always_ff @(posedge clk) begin
      if (!rst || jump_flag) begin
         pc_o    <= {ADDR_W{1'b0}};
         inst_o  <= {INST_W{1'b0}};
         valid_o <= 1'b0;
      end else if (hold_s) begin
         pc_o    <= pc_o;
         inst_o  <= inst_o;
         valid_o <= valid_o;
      end else if (pop_s) begin
         pc_o    <= pc_mem_r[rd_ptr_r];
         inst_o  <= inst_mem_r[rd_ptr_r];
         valid_o <= 1'b1;
      end else if (bypass_s) begin
         pc_o    <= pc_i;
         inst_o  <= inst_i;
         valid_o <= 1'b1;
      end else begin
         // Bubble, or idle with an empty queue.
         pc_o    <= {ADDR_W{1'b0}};
         inst_o  <= {INST_W{1'b0}};
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
// Self-checking bench for if_id_queue (DEPTH=4). The main test is a table of
// per-cycle vectors. Each vector holds the inputs plus the expected in_ready
// (before the edge), and the expected valid_o and count_o (after the edge).
// A scoreboard queue supplies the expected pc_o / inst_o: accepted PCs are
// pushed when driven and popped when ID advances. A hand-written wrap test
// follows. It accepts every cycle and alternates one-cycle holds, then drains.
// ---------------------------------------------------------------------------
module tb_if_id_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
   localparam logic [4:0] ST_N = 5'b00000;
   localparam logic [4:0] ST_H = 5'b00100;
   localparam logic [4:0] ST_B = 5'b00010;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [31:0]      pc_i;
   logic [31:0]      inst_i;
   logic             in_ready;
   logic             jump_flag;
   logic [4:0]       stall_signal;
   logic [31:0]      pc_o;
   logic [31:0]      inst_o;
   logic             valid_o;
   logic [CNT_W-1:0] count_o;

   if_id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc_i(pc_i), .inst_i(inst_i),
      .in_ready(in_ready), .jump_flag(jump_flag), .stall_signal(stall_signal),
      .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        in_valid;
      logic [31:0] pc;
      logic        jump;
      logic [4:0]  stall;
      logic        exp_ready;
      logic        exp_valid;
      logic [2:0]  exp_cnt;
   } vec_t;

   vec_t        tab [35];
   logic [31:0] sb_q [$];
   logic        m_valid;
   logic [31:0] m_pc;
   logic        last_acc;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0] ^ 16'hA5C3, pc[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, check in_ready, update the model, check outputs.
   task automatic step(input vec_t v, input bit use_tab);
      logic m_ready;
      logic acc;
      @(negedge clk);
      rst          = v.rst;
      in_valid     = v.in_valid;
      pc_i         = v.pc;
      inst_i       = inst_of(v.pc);
      jump_flag    = v.jump;
      stall_signal = v.stall;
      #1;
      m_ready = v.rst && (sb_q.size() != DEPTH);
      chk("in_ready", {31'd0, in_ready}, {31'd0, use_tab ? v.exp_ready : m_ready});
      acc = v.in_valid && m_ready;
      last_acc = acc;
      if (!v.rst || v.jump) begin
         sb_q.delete();
         m_valid = 1'b0;
         m_pc    = 32'd0;
      end else if (v.stall[2]) begin
         if (acc) sb_q.push_back(v.pc);
      end else if (v.stall[1]) begin
         if (acc) sb_q.push_back(v.pc);
         m_valid = 1'b0;
         m_pc    = 32'd0;
      end else begin
         if (acc) sb_q.push_back(v.pc);
         if (sb_q.size() > 0) begin
            m_pc    = sb_q.pop_front();
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
            m_pc    = 32'd0;
         end
      end
      @(posedge clk);
      #1;
      chk("valid_o", {31'd0, valid_o}, {31'd0, use_tab ? v.exp_valid : m_valid});
      chk("count_o", {29'd0, count_o}, use_tab ? {29'd0, v.exp_cnt} : sb_q.size());
      chk("pc_o", pc_o, m_pc);
      chk("inst_o", inst_o, m_valid ? inst_of(m_pc) : 32'd0);
   endtask

   initial begin
      vec_t        w;
      logic [31:0] pc_next;

      rst = 1'b0; in_valid = 1'b0; pc_i = 32'd0; inst_i = 32'd0;
      jump_flag = 1'b0; stall_signal = 5'd0;
      m_valid = 1'b0; m_pc = 32'd0; last_acc = 1'b0;

      //           rst   vld   pc          jmp   stall   rdy   val   cnt
      // reset held for two cycles with an instruction presented, then released
      tab[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, ST_N, 1'b0, 1'b0, 3'd0};
      tab[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, ST_N, 1'b0, 1'b0, 3'd0};
      tab[2]  = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b0, 3'd0};
      // bypass path
      tab[3]  = '{1'b1, 1'b1, 32'h000, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};
      tab[4]  = '{1'b1, 1'b1, 32'h004, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};
      tab[5]  = '{1'b1, 1'b1, 32'h008, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};
      // hold fill up to full; 0x20 is refused
      tab[6]  = '{1'b1, 1'b1, 32'h010, 1'b0, ST_H, 1'b1, 1'b1, 3'd1};
      tab[7]  = '{1'b1, 1'b1, 32'h014, 1'b0, ST_H, 1'b1, 1'b1, 3'd2};
      tab[8]  = '{1'b1, 1'b1, 32'h018, 1'b0, ST_H, 1'b1, 1'b1, 3'd3};
      tab[9]  = '{1'b1, 1'b1, 32'h01C, 1'b0, ST_H, 1'b1, 1'b1, 3'd4};
      tab[10] = '{1'b1, 1'b1, 32'h020, 1'b0, ST_H, 1'b0, 1'b1, 3'd4};
      // release: drain in order (first pop cycle still shows full)
      tab[11] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b0, 1'b1, 3'd3};
      tab[12] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b1, 3'd2};
      tab[13] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b1, 3'd1};
      tab[14] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};
      tab[15] = '{1'b1, 1'b1, 32'h020, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};
      tab[16] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b0, 3'd0};
      // bubble with two queued entries; unused stall bits are ignored
      tab[17] = '{1'b1, 1'b1, 32'h040, 1'b0, ST_H, 1'b1, 1'b0, 3'd1};
      tab[18] = '{1'b1, 1'b1, 32'h044, 1'b0, ST_H, 1'b1, 1'b0, 3'd2};
      tab[19] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_B, 1'b1, 1'b0, 3'd2};
      tab[20] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b1, 3'd1};
      tab[21] = '{1'b1, 1'b0, 32'h000, 1'b0, 5'b11001, 1'b1, 1'b1, 3'd0};
      // flush with three queued entries and a coincident accept
      tab[22] = '{1'b1, 1'b1, 32'h060, 1'b0, ST_H, 1'b1, 1'b1, 3'd1};
      tab[23] = '{1'b1, 1'b1, 32'h064, 1'b0, ST_H, 1'b1, 1'b1, 3'd2};
      tab[24] = '{1'b1, 1'b1, 32'h068, 1'b0, ST_H, 1'b1, 1'b1, 3'd3};
      tab[25] = '{1'b1, 1'b1, 32'h080, 1'b1, ST_N, 1'b1, 1'b0, 3'd0};
      tab[26] = '{1'b1, 1'b1, 32'h200, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};
      tab[27] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b0, 3'd0};
      // jump beats hold
      tab[28] = '{1'b1, 1'b1, 32'h300, 1'b0, ST_H, 1'b1, 1'b0, 3'd1};
      tab[29] = '{1'b1, 1'b0, 32'h000, 1'b1, ST_H, 1'b1, 1'b0, 3'd0};
      // bubble with an accept on an empty queue enqueues rather than bypasses
      tab[30] = '{1'b1, 1'b1, 32'h304, 1'b0, ST_B, 1'b1, 1'b0, 3'd1};
      tab[31] = '{1'b1, 1'b0, 32'h000, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};
      // mid-operation reset, then bypass
      tab[32] = '{1'b1, 1'b1, 32'h308, 1'b0, ST_H, 1'b1, 1'b1, 3'd1};
      tab[33] = '{1'b0, 1'b1, 32'h30C, 1'b0, ST_N, 1'b0, 1'b0, 3'd0};
      tab[34] = '{1'b1, 1'b1, 32'h310, 1'b0, ST_N, 1'b1, 1'b1, 3'd0};

      for (int i = 0; i < 35; i++) begin
         step(tab[i], 1'b1);
      end

      // Wrap/concurrency: accept every cycle, hold on even cycles, re-present if refused.
      pc_next = 32'h1000;
      for (int i = 0; i < 24; i++) begin
         w = '{1'b1, 1'b1, pc_next, 1'b0, ((i % 2) == 0) ? ST_H : ST_N, 1'b0, 1'b0, 3'd0};
         step(w, 1'b0);
         if (last_acc) pc_next = pc_next + 32'd4;
         checks++;
         if (count_o > 3'd4) begin
            errors++;
            $display("FAIL count_max at %0t: got %0d expected <= 4", $time, count_o);
         end
      end
      for (int i = 0; i < 6; i++) begin
         w = '{1'b1, 1'b0, 32'd0, 1'b0, ST_N, 1'b0, 1'b0, 3'd0};
         step(w, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
